// File: rtl/min_max_finder_param.sv
// Min/max search engine over an internal DEPTH x WIDTH array.
// The host fills the array, pulses start, and reads back max/min values with their first indices.
`timescale 1ns/1ps
module min_max_finder_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_resetN,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_signedMode,
    input  logic              i_ack,
    output logic [WIDTH-1:0]  o_max,
    output logic [WIDTH-1:0]  o_min,
    output logic [ADDR_W-1:0] o_maxIdx,
    output logic [ADDR_W-1:0] o_minIdx,
    output logic              o_qi,
    output logic              o_ql,
    output logic              o_qc,
    output logic              o_qd
);

    typedef enum logic [1:0] {S_INI, S_LOAD, S_COMP, S_DONE} state_t;

    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]   r_len;
    logic              r_signed;
    logic [ADDR_W-1:0] r_idx;
    logic [WIDTH-1:0]  r_max;
    logic [WIDTH-1:0]  r_min;
    logic [ADDR_W-1:0] r_maxIdx;
    logic [ADDR_W-1:0] r_minIdx;

    logic              w_wrOk;
    logic [WIDTH-1:0]  w_elem;
    logic              w_gt;
    logic              w_lt;
    logic              w_last;
    logic [ADDR_W:0]   w_lenMapped;

    // The array is frozen while a search is in flight and is never cleared by reset.
    assign w_wrOk = (r_state == S_INI) || (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_wrEn && w_wrOk) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign w_elem      = r_mem[r_idx];
    assign w_gt        = r_signed ? ($signed(w_elem) > $signed(r_max)) : (w_elem > r_max);
    assign w_lt        = r_signed ? ($signed(w_elem) < $signed(r_min)) : (w_elem < r_min);
    assign w_last      = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_lenMapped = ((i_len == '0) || (i_len > LEN_FULL)) ? LEN_FULL : i_len;

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_state  <= S_INI;
            r_len    <= LEN_FULL;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_max    <= '0;
            r_min    <= '0;
            r_maxIdx <= '0;
            r_minIdx <= '0;
        end else begin
            case (r_state)
                S_INI: begin
                    if (i_start) begin
                        r_len    <= w_lenMapped;
                        r_signed <= i_signedMode;
                        r_idx    <= '0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_max    <= w_elem;
                    r_min    <= w_elem;
                    r_maxIdx <= '0;
                    r_minIdx <= '0;
                    r_idx    <= ADDR_W'(1);
                    r_state  <= (r_len == (ADDR_W+1)'(1)) ? S_DONE : S_COMP;
                end
                S_COMP: begin
                    // Strict compares keep the earliest index on ties.
                    if (w_gt) begin
                        r_max    <= w_elem;
                        r_maxIdx <= r_idx;
                    end
                    if (w_lt) begin
                        r_min    <= w_elem;
                        r_minIdx <= r_idx;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_ack) begin
                        r_state <= S_INI;
                    end
                end
                default: r_state <= S_INI;
            endcase
        end
    end

    assign o_max    = r_max;
    assign o_min    = r_min;
    assign o_maxIdx = r_maxIdx;
    assign o_minIdx = r_minIdx;
    assign o_qi     = (r_state == S_INI);
    assign o_ql     = (r_state == S_LOAD);
    assign o_qc     = (r_state == S_COMP);
    assign o_qd     = (r_state == S_DONE);

endmodule

// File: tb/tb_min_max_finder_param.sv
// Directed bench for min_max_finder_param: hand-computed max/min/index/latency expectations.
`timescale 1ns/1ps
module tb_min_max_finder_param;

    logic       clk = 1'b0;
    logic       resetN;
    logic       wrEn;
    logic [3:0] wrAddr;
    logic [7:0] wrData;
    logic       start;
    logic [4:0] len;
    logic       signedMode;
    logic       ack;
    logic [7:0] maxV;
    logic [7:0] minV;
    logic [3:0] maxIdx;
    logic [3:0] minIdx;
    logic       qi, ql, qc, qd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    min_max_finder_param #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
        .i_clk(clk), .i_resetN(resetN), .i_wrEn(wrEn), .i_wrAddr(wrAddr),
        .i_wrData(wrData), .i_start(start), .i_len(len), .i_signedMode(signedMode),
        .i_ack(ack), .o_max(maxV), .o_min(minV), .o_maxIdx(maxIdx), .o_minIdx(minIdx),
        .o_qi(qi), .o_ql(ql), .o_qc(qc), .o_qd(qd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        tick();
        wrEn   = 1'b0;
    endtask

    task automatic startRun(input logic [4:0] l, input logic sgn);
        start      = 1'b1;
        len        = l;
        signedMode = sgn;
        tick();
        start      = 1'b0;
    endtask

    // Counts edges after the Start edge until Qd rises, bounded.
    task automatic waitDone(input string tag, input int expCycles);
        int n = 0;
        while (!qd && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, n, expCycles);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] eMax, input logic [3:0] eMaxIdx,
                               input logic [7:0] eMin, input logic [3:0] eMinIdx);
        checkOutput({tag, "_max"},    maxV,   eMax);
        checkOutput({tag, "_maxIdx"}, maxIdx, eMaxIdx);
        checkOutput({tag, "_min"},    minV,   eMin);
        checkOutput({tag, "_minIdx"}, minIdx, eMinIdx);
    endtask

    task automatic doAck();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] t1 [16];
        t1 = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
               8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};

        resetN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
        start = 1'b0; len = '0; signedMode = 1'b0; ack = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        checkOutput("rst_qstate", {qi, ql, qc, qd}, 4'b1000);
        checkResult("rst", 8'h00, 4'd0, 8'h00, 4'd0);

        // T1: unsigned full-depth scan; the first 02 sits at index 10.
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), t1[i]);
        startRun(5'd0, 1'b0);
        checkOutput("t1_load_state", {qi, ql, qc, qd}, 4'b0100);
        tick();
        checkOutput("t1_comp_state", {qi, ql, qc, qd}, 4'b0010);
        waitDone("t1_latency", 15);
        checkResult("t1", 8'hF5, 4'd15, 8'h02, 4'd10);

        // T2: same data, unsigned then signed interpretation.
        applyStimulus(4'd0, 8'h7F);
        applyStimulus(4'd1, 8'h80);
        applyStimulus(4'd2, 8'h01);
        applyStimulus(4'd3, 8'hFF);
        doAck();
        startRun(5'd4, 1'b0);
        waitDone("t2u_latency", 4);
        checkResult("t2u", 8'hFF, 4'd3, 8'h01, 4'd2);
        doAck();
        startRun(5'd4, 1'b1);
        waitDone("t2s_latency", 4);
        checkResult("t2s", 8'h7F, 4'd0, 8'h80, 4'd1);

        // T3: all-equal array keeps index 0 for both.
        doAck();
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 8'h5A);
        startRun(5'd16, 1'b0);
        waitDone("t3_latency", 16);
        checkResult("t3", 8'h5A, 4'd0, 8'h5A, 4'd0);

        // T4: single element, then an oversize length that maps to full depth.
        doAck();
        applyStimulus(4'd0, 8'hC3);
        startRun(5'd1, 1'b0);
        waitDone("t4_latency", 1);
        checkResult("t4", 8'hC3, 4'd0, 8'hC3, 4'd0);
        doAck();
        startRun(5'd20, 1'b0);
        waitDone("t4big_latency", 16);
        checkResult("t4big", 8'hC3, 4'd0, 8'h5A, 4'd1);

        // T5: writes and Start during the search are ignored.
        doAck();
        applyStimulus(4'd0, 8'h10);
        applyStimulus(4'd1, 8'h20);
        applyStimulus(4'd2, 8'h30);
        applyStimulus(4'd3, 8'h40);
        startRun(5'd4, 1'b0);
        wrEn = 1'b1; wrAddr = 4'd2; wrData = 8'h00; start = 1'b1;
        tick();
        tick();
        wrEn = 1'b0;
        waitDone("t5_latency", 2);
        checkResult("t5", 8'h40, 4'd3, 8'h10, 4'd0);
        tick();
        checkOutput("t5_start_in_done", {qi, ql, qc, qd}, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        checkOutput("t5_start_ack_state", {qi, ql, qc, qd}, 4'b1000);
        checkOutput("t5_hold_after_ack", maxV, 8'h40);
        tick();
        checkOutput("t5_still_ini", {qi, ql, qc, qd}, 4'b1000);

        // T6: reset mid-COMP clears everything, fresh run then works.
        startRun(5'd4, 1'b1);
        tick();
        tick();
        checkOutput("t6_in_comp", qc, 1'b1);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checkOutput("t6_rst_state", {qi, ql, qc, qd}, 4'b1000);
        checkResult("t6_rst", 8'h00, 4'd0, 8'h00, 4'd0);
        startRun(5'd4, 1'b1);
        waitDone("t6_latency", 4);
        checkResult("t6", 8'h40, 4'd3, 8'h10, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
